// File: rtl/bsg_axil_fifo_master_pipelined.sv
// Valid/ready-and command stream to AXI4-Lite manager bridge with up to
// outstanding_els_p transactions in flight and strictly in-order R/B return.
module bsg_axil_fifo_master_pipelined #(
  parameter int axil_data_width_p  = 32,
  parameter int axil_addr_width_p  = 32,
  parameter int cmd_els_p          = 2,
  parameter int outstanding_els_p  = 4,
  localparam int axil_mask_width_lp = axil_data_width_p / 8,
  localparam int credit_width_lp    = $clog2(outstanding_els_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic [axil_data_width_p-1:0]  data_i,
  input  logic [axil_addr_width_p-1:0]  addr_i,
  input  logic [axil_mask_width_lp-1:0] wmask_i,
  input  logic                          w_i,
  input  logic                          v_i,
  output logic                          ready_and_o,

  output logic [axil_data_width_p-1:0]  data_o,
  output logic [1:0]                    resp_o,
  output logic                          w_o,
  output logic                          v_o,
  input  logic                          ready_and_i,

  output logic [credit_width_lp-1:0]    credits_used_o,

  output logic [axil_addr_width_p-1:0]  m_axil_awaddr_o,
  output logic [2:0]                    m_axil_awprot_o,
  output logic                          m_axil_awvalid_o,
  input  logic                          m_axil_awready_i,

  output logic [axil_data_width_p-1:0]  m_axil_wdata_o,
  output logic [axil_mask_width_lp-1:0] m_axil_wstrb_o,
  output logic                          m_axil_wvalid_o,
  input  logic                          m_axil_wready_i,

  input  logic [1:0]                    m_axil_bresp_i,
  input  logic                          m_axil_bvalid_i,
  output logic                          m_axil_bready_o,

  output logic [axil_addr_width_p-1:0]  m_axil_araddr_o,
  output logic [2:0]                    m_axil_arprot_o,
  output logic                          m_axil_arvalid_o,
  input  logic                          m_axil_arready_i,

  input  logic [axil_data_width_p-1:0]  m_axil_rdata_i,
  input  logic [1:0]                    m_axil_rresp_i,
  input  logic                          m_axil_rvalid_i,
  output logic                          m_axil_rready_o
);

  // Every channel here is valid/ready: a transfer happens on the rising clock
  // edge where both are 1; valid never waits on ready, and once raised it holds
  // with a stable payload until that transfer.

  localparam logic [2:0] prot_dsn_lp = 3'b000;  // data, secure, normal
  localparam int cmd_width_lp = 1 + axil_addr_width_p + axil_data_width_p + axil_mask_width_lp;
  localparam int cmd_ptr_w_lp = $clog2(cmd_els_p);
  localparam int cmd_cnt_w_lp = $clog2(cmd_els_p + 1);
  localparam int ret_ptr_w_lp = (outstanding_els_p > 1) ? $clog2(outstanding_els_p) : 1;

  // ---------------- command FIFO ----------------
  logic [cmd_width_lp-1:0] cmd_mem [cmd_els_p];
  logic [cmd_ptr_w_lp-1:0] cmd_wptr_r, cmd_rptr_r;
  logic [cmd_cnt_w_lp-1:0] cmd_cnt_r;
  logic                    cmd_enq, cmd_deq, cmd_v;

  logic                          cmd_w;
  logic [axil_addr_width_p-1:0]  cmd_addr;
  logic [axil_data_width_p-1:0]  cmd_data;
  logic [axil_mask_width_lp-1:0] cmd_mask;

  function automatic logic [cmd_ptr_w_lp-1:0] cmd_ptr_inc(input logic [cmd_ptr_w_lp-1:0] p);
    return (p == cmd_ptr_w_lp'(cmd_els_p - 1)) ? '0 : p + cmd_ptr_w_lp'(1);
  endfunction

  assign ready_and_o = (cmd_cnt_r != cmd_cnt_w_lp'(cmd_els_p));
  assign cmd_enq     = v_i & ready_and_o;
  assign cmd_v       = (cmd_cnt_r != '0);
  assign {cmd_w, cmd_addr, cmd_data, cmd_mask} = cmd_mem[cmd_rptr_r];

  always_ff @(posedge clk_i) begin
    if (cmd_enq) cmd_mem[cmd_wptr_r] <= {w_i, addr_i, data_i, wmask_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_wptr_r <= '0;
      cmd_rptr_r <= '0;
      cmd_cnt_r  <= '0;
    end else begin
      if (cmd_enq) cmd_wptr_r <= cmd_ptr_inc(cmd_wptr_r);
      if (cmd_deq) cmd_rptr_r <= cmd_ptr_inc(cmd_rptr_r);
      if (cmd_enq & ~cmd_deq)      cmd_cnt_r <= cmd_cnt_r + cmd_cnt_w_lp'(1);
      else if (~cmd_enq & cmd_deq) cmd_cnt_r <= cmd_cnt_r - cmd_cnt_w_lp'(1);
    end
  end

  // ---------------- issue ----------------
  logic [credit_width_lp-1:0] credits_r;
  logic issue_ok, aw_sent_r, w_sent_r;
  logic aw_hs, w_hs, ar_hs, aw_done, w_done, wr_deq, ret_pop;

  assign issue_ok = cmd_v & (credits_r < credit_width_lp'(outstanding_els_p));

  assign m_axil_araddr_o  = cmd_addr;
  assign m_axil_arprot_o  = prot_dsn_lp;
  assign m_axil_arvalid_o = issue_ok & ~cmd_w;

  assign m_axil_awaddr_o  = cmd_addr;
  assign m_axil_awprot_o  = prot_dsn_lp;
  assign m_axil_awvalid_o = issue_ok & cmd_w & ~aw_sent_r;

  assign m_axil_wdata_o   = cmd_data;
  assign m_axil_wstrb_o   = cmd_mask;
  assign m_axil_wvalid_o  = issue_ok & cmd_w & ~w_sent_r;

  assign ar_hs   = m_axil_arvalid_o & m_axil_arready_i;
  assign aw_hs   = m_axil_awvalid_o & m_axil_awready_i;
  assign w_hs    = m_axil_wvalid_o  & m_axil_wready_i;
  assign aw_done = aw_sent_r | aw_hs;
  assign w_done  = w_sent_r  | w_hs;
  assign wr_deq  = issue_ok & cmd_w & aw_done & w_done;
  assign cmd_deq = ar_hs | wr_deq;

  // The head write cannot lose issue_ok while half-sent: credits only fall
  // until it dequeues, so the held AW/W valids stay up.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_sent_r <= 1'b0;
      w_sent_r  <= 1'b0;
    end else if (wr_deq) begin
      aw_sent_r <= 1'b0;
      w_sent_r  <= 1'b0;
    end else begin
      if (aw_hs) aw_sent_r <= 1'b1;
      if (w_hs)  w_sent_r  <= 1'b1;
    end
  end

  // ---------------- return-order FIFO and credits ----------------
  logic                    ret_mem [outstanding_els_p];
  logic [ret_ptr_w_lp-1:0] ret_wptr_r, ret_rptr_r;
  logic                    head_w, head_v;

  function automatic logic [ret_ptr_w_lp-1:0] ret_ptr_inc(input logic [ret_ptr_w_lp-1:0] p);
    return (p == ret_ptr_w_lp'(outstanding_els_p - 1)) ? '0 : p + ret_ptr_w_lp'(1);
  endfunction

  assign head_w = ret_mem[ret_rptr_r];
  assign head_v = (credits_r != '0);

  always_ff @(posedge clk_i) begin
    if (cmd_deq) ret_mem[ret_wptr_r] <= cmd_w;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ret_wptr_r <= '0;
      ret_rptr_r <= '0;
      credits_r  <= '0;
    end else begin
      if (cmd_deq) ret_wptr_r <= ret_ptr_inc(ret_wptr_r);
      if (ret_pop) ret_rptr_r <= ret_ptr_inc(ret_rptr_r);
      if (cmd_deq & ~ret_pop)      credits_r <= credits_r + credit_width_lp'(1);
      else if (~cmd_deq & ret_pop) credits_r <= credits_r - credit_width_lp'(1);
    end
  end

  assign credits_used_o = credits_r;

  // ---------------- response path ----------------
  assign v_o     = head_v & (head_w ? m_axil_bvalid_i : m_axil_rvalid_i);
  assign data_o  = head_w ? '0 : m_axil_rdata_i;
  assign resp_o  = head_w ? m_axil_bresp_i : m_axil_rresp_i;
  assign w_o     = head_w;
  assign ret_pop = v_o & ready_and_i;

  assign m_axil_bready_o = head_v &  head_w & ready_and_i;
  assign m_axil_rready_o = head_v & ~head_w & ready_and_i;

endmodule

// File: tb/tb_bsg_axil_fifo_master_pipelined.sv
// Directed bench for bsg_axil_fifo_master_pipelined: AXIL subordinate model,
// command driver, and an in-order response scoreboard.
module tb_bsg_axil_fifo_master_pipelined;

  logic        clk, reset;
  logic [31:0] data_i, addr_i;
  logic [3:0]  wmask_i;
  logic        w_i, v_i, ready_and_o;
  logic [31:0] data_o;
  logic [1:0]  resp_o;
  logic        w_o, v_o, ready_and_i;
  logic [2:0]  credits_used_o;

  logic [31:0] awaddr, wdata, bsg_araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  bsg_axil_fifo_master_pipelined dut (
    .clk_i(clk), .reset_i(reset),
    .data_i(data_i), .addr_i(addr_i), .wmask_i(wmask_i), .w_i(w_i), .v_i(v_i),
    .ready_and_o(ready_and_o),
    .data_o(data_o), .resp_o(resp_o), .w_o(w_o), .v_o(v_o), .ready_and_i(ready_and_i),
    .credits_used_o(credits_used_o),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(bsg_araddr), .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AXIL subordinate model ----------------
  logic        r_en, b_en;
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  int          w_pend = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] last_wdata, last_awaddr;
  logic [3:0]  last_wstrb;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hCAFE_0000 | a);
  endfunction

  always @(posedge clk) begin : sub_blk
    logic [31:0] a;
    if (reset) begin
      ar_q.delete();
      aw_q.delete();
      w_pend = 0;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      bvalid <= 1'b0; bresp <= 2'b00;
    end else begin
      if (arvalid && arready) begin ar_q.push_back(bsg_araddr); ar_cnt++; end
      if (awvalid && awready) begin aw_q.push_back(awaddr); last_awaddr = awaddr; aw_cnt++; end
      if (wvalid && wready) begin w_pend++; w_cnt++; last_wdata = wdata; last_wstrb = wstrb; end
      if (!rvalid || rready) begin
        if (r_en && ar_q.size() != 0) begin
          a = ar_q.pop_front();
          rvalid <= 1'b1;
          rdata  <= rdata_for(a);
          rresp  <= (a == 32'hBAD0) ? 2'b11 : 2'b00;
        end else rvalid <= 1'b0;
      end
      if (!bvalid || bready) begin
        if (b_en && aw_q.size() != 0 && w_pend > 0) begin
          a = aw_q.pop_front();
          w_pend--;
          bvalid <= 1'b1;
          bresp  <= (a == 32'hBAD4) ? 2'b10 : 2'b00;
        end else bvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard: {w, resp, data} ----------------
  logic [34:0] exp_q[$];

  always @(negedge clk) begin : monitor
    logic [34:0] e;
    if (!reset && v_o && ready_and_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got w=%0b resp=%0h data=%0h expected none", w_o, resp_o, data_o);
      end else begin
        e = exp_q.pop_front();
        if ({w_o, resp_o, data_o} !== e) begin
          errors++;
          $display("FAIL resp: got w=%0b resp=%0h data=%0h expected w=%0b resp=%0h data=%0h",
                   w_o, resp_o, data_o, e[34], e[33:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [1:0] er, input logic [31:0] ed);
    bit ok = 0;
    w_i = w; addr_i = a; data_i = d; wmask_i = m; v_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready_and_o) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      exp_q.push_back({w, er, ed});
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready_and_o=0 expected 1 (addr %0h)", a);
    end
    v_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(name, exp_q.size(), 0);
    wait_cycles(2);
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    reset = 1'b1; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; wmask_i = '0;
    ready_and_i = 1'b1; awready = 1'b1; wready = 1'b1; arready = 1'b1;
    r_en = 1'b1; b_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_credits", credits_used_o, 0);
    chk("reset_ready", ready_and_o, 1);
    chk("reset_valids", {v_o, arvalid, awvalid, wvalid, bready, rready}, 0);
    chk("prot", {awprot, arprot}, 0);

    // 1: single read
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF);
    wait_drain("t1_drain");
    chk("t1_credits", credits_used_o, 0);

    // 2: W accepted three cycles before AW
    awready = 1'b0; wready = 1'b1;
    base = aw_cnt;
    send_cmd(1'b1, 32'h20, 32'h12345678, 4'hF, 2'b00, 32'h0);
    wait_cycles(4);
    chk("t2_w_once", w_cnt, 3'd1 + 0);
    chk("t2_no_aw", aw_cnt - base, 0);
    chk("t2_wvalid_dropped", wvalid, 0);
    chk("t2_awvalid_held", awvalid, 1);
    chk("t2_credits_wait", credits_used_o, 0);
    awready = 1'b1;
    wait_cycles(1);
    chk("t2_aw_once", aw_cnt - base, 1);
    chk("t2_credits_deq", credits_used_o, 1);
    chk("t2_wpayload", {last_awaddr, last_wdata, last_wstrb}, {32'h20, 32'h12345678, 4'hF});
    wait_drain("t2_drain");
    chk("t2_w_total", w_cnt, 1);

    // 3: six reads, R withheld
    r_en = 1'b0;
    base = ar_cnt;
    for (int i = 0; i < 6; i++)
      send_cmd(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 2'b00, 32'hCAFE_0100 + 32'(4 * i));
    wait_cycles(3);
    chk("t3_ar_issued", ar_cnt - base, 4);
    chk("t3_credits_full", credits_used_o, 4);
    chk("t3_ready_low", ready_and_o, 0);
    chk("t3_no_resp", v_o, 0);
    r_en = 1'b1;
    wait_drain("t3_drain");
    chk("t3_ar_total", ar_cnt - base, 6);
    chk("t3_credits_end", credits_used_o, 0);

    // 4: write then read, R returns first
    b_en = 1'b0;
    send_cmd(1'b1, 32'h30, 32'h0000_55AA, 4'h3, 2'b00, 32'h0);
    send_cmd(1'b0, 32'h34, 32'h0, 4'h0, 2'b00, 32'hCAFE_0034);
    wait_cycles(4);
    chk("t4_rvalid", rvalid, 1);
    chk("t4_rready_held", rready, 0);
    chk("t4_vo_low", v_o, 0);
    chk("t4_credits", credits_used_o, 2);
    b_en = 1'b1;
    wait_drain("t4_drain");

    // 5: DECERR read under consumer backpressure, SLVERR write, then normal read
    ready_and_i = 1'b0;
    send_cmd(1'b0, 32'hBAD0, 32'h0, 4'h0, 2'b11, 32'hCAFE_BAD0);
    send_cmd(1'b1, 32'hBAD4, 32'h1, 4'h1, 2'b10, 32'h0);
    send_cmd(1'b0, 32'h44, 32'h0, 4'h0, 2'b00, 32'hCAFE_0044);
    wait_cycles(4);
    chk("t5_head_err", {v_o, w_o, resp_o, rready}, {1'b1, 1'b0, 2'b11, 1'b0});
    ready_and_i = 1'b1;
    wait_drain("t5_drain");

    // 6: reset with two reads outstanding
    r_en = 1'b0;
    send_cmd(1'b0, 32'h50, 32'h0, 4'h0, 2'b00, 32'hCAFE_0050);
    send_cmd(1'b0, 32'h54, 32'h0, 4'h0, 2'b00, 32'hCAFE_0054);
    wait_cycles(3);
    chk("t6_credits_before", credits_used_o, 2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    chk("t6_credits_after", credits_used_o, 0);
    chk("t6_valids", {v_o, arvalid, awvalid, wvalid, bready, rready}, 0);
    chk("t6_ready", ready_and_o, 1);
    r_en = 1'b1;
    send_cmd(1'b0, 32'h60, 32'h0, 4'h0, 2'b00, 32'hCAFE_0060);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
